// File: rtl/irq_trap_ctrl.sv
// irq_trap_ctrl: machine-level interrupt receiver and trap requester.
//
// Samples the timer, software and external interrupt levels into mip. It holds
// mie and the global enable pair (gie = mstatus.MIE, mpie = mstatus.MPIE). It picks
// the highest-priority enabled pending source (MEI > MSI > MTI) and presents a
// stable trap request to the core through a req/ack handshake. mret restores
// the global enable.
//
// Optional build macro: IRQ_SYNC_EN
//   Defined   - each irq input goes through a 2-flop synchronizer before mip.
//   Undefined - the mip register samples the irq inputs directly.
//
// Ports:
//   clk_i, rst_ni        core clock, asynchronous active-low reset
//   timer_irq_i          level timer interrupt (CLINT)
//   soft_irq_i           level software interrupt (CLINT msip)
//   ext_irq_i            level external interrupt
//   mie_we_i/wdata_i     mie write port (only MSI/MTI/MEI bits are kept)
//   gie_we_i/wdata_i     mstatus.MIE write port
//   irq_ack_i            core accepts the pending trap request
//   mret_i               core retires mret
//   irq_req_o            trap request, held until acknowledged or cancelled
//   irq_cause_o          mcause for the request; kept until the next request
//   mip_o, mie_o         architectural views (only MSI/MTI/MEI bits can be set)
//   gie_o, mpie_o        mstatus.MIE / mstatus.MPIE
//   in_handler_o         high while a trap is being handled
module irq_trap_ctrl #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MSI_BIT = 3,
    parameter int unsigned MTI_BIT = 7,
    parameter int unsigned MEI_BIT = 11
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            timer_irq_i,
    input  logic            soft_irq_i,
    input  logic            ext_irq_i,
    input  logic            mie_we_i,
    input  logic [XLEN-1:0] mie_wdata_i,
    input  logic            gie_we_i,
    input  logic            gie_wdata_i,
    input  logic            irq_ack_i,
    input  logic            mret_i,
    output logic            irq_req_o,
    output logic [XLEN-1:0] irq_cause_o,
    output logic [XLEN-1:0] mip_o,
    output logic [XLEN-1:0] mie_o,
    output logic            gie_o,
    output logic            mpie_o,
    output logic            in_handler_o
);

    // Internal source vectors are packed as {ext, timer, soft}.
    localparam int unsigned IdxMsi = 0;
    localparam int unsigned IdxMti = 1;
    localparam int unsigned IdxMei = 2;

    localparam logic [XLEN-1:0] IrqFlag  = XLEN'(1) << (XLEN - 1);
    localparam logic [XLEN-1:0] CauseMsi = IrqFlag | XLEN'(3);
    localparam logic [XLEN-1:0] CauseMti = IrqFlag | XLEN'(7);
    localparam logic [XLEN-1:0] CauseMei = IrqFlag | XLEN'(11);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHandler
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      irq_raw;
    logic [2:0]      irq_in;
    logic [2:0]      mip_q;
    logic [2:0]      mie_q, mie_d;
    logic [2:0]      pending;
    logic            gie_q, gie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] cause_sel;

    // Only three bits of the mie write data are architecturally meaningful.
    logic            unused_mie_wdata;
    assign unused_mie_wdata = ^mie_wdata_i;

    assign irq_raw = {ext_irq_i, timer_irq_i, soft_irq_i};

`ifdef IRQ_SYNC_EN
    logic [2:0] sync1_q, sync2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_raw;
            sync2_q <= sync1_q;
        end
    end

    assign irq_in = sync2_q;
`else
    assign irq_in = irq_raw;
`endif

    always_comb begin
        mie_d = mie_q;
        if (mie_we_i) begin
            mie_d = {mie_wdata_i[MEI_BIT], mie_wdata_i[MTI_BIT], mie_wdata_i[MSI_BIT]};
        end
    end

    assign pending = mip_q & mie_q;

    always_comb begin
        cause_sel = '0;
        if (pending[IdxMei]) begin
            cause_sel = CauseMei;
        end else if (pending[IdxMsi]) begin
            cause_sel = CauseMsi;
        end else if (pending[IdxMti]) begin
            cause_sel = CauseMti;
        end
    end

    always_comb begin
        state_d = state_q;
        gie_d   = gie_q;
        mpie_d  = mpie_q;
        cause_d = cause_q;
        case (state_q)
            StIdle: begin
                if (gie_we_i) begin
                    gie_d = gie_wdata_i;
                end
                if (gie_q && (pending != 3'b000)) begin
                    state_d = StReq;
                    cause_d = cause_sel;
                end
            end
            StReq: begin
                // Ack takes priority over a simultaneous gie write.
                if (irq_ack_i) begin
                    state_d = StHandler;
                    mpie_d  = gie_q;
                    gie_d   = 1'b0;
                end else if (gie_we_i) begin
                    gie_d = gie_wdata_i;
                    if (!gie_wdata_i) begin
                        state_d = StIdle;
                    end
                end
            end
            StHandler: begin
                // mret takes priority over a simultaneous gie write.
                if (mret_i) begin
                    state_d = StIdle;
                    gie_d   = mpie_q;
                    mpie_d  = 1'b1;
                end else if (gie_we_i) begin
                    gie_d = gie_wdata_i;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            mip_q   <= '0;
            mie_q   <= '0;
            gie_q   <= 1'b0;
            mpie_q  <= 1'b0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            mip_q   <= irq_in;
            mie_q   <= mie_d;
            gie_q   <= gie_d;
            mpie_q  <= mpie_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        mip_o          = '0;
        mip_o[MSI_BIT] = mip_q[IdxMsi];
        mip_o[MTI_BIT] = mip_q[IdxMti];
        mip_o[MEI_BIT] = mip_q[IdxMei];
        mie_o          = '0;
        mie_o[MSI_BIT] = mie_q[IdxMsi];
        mie_o[MTI_BIT] = mie_q[IdxMti];
        mie_o[MEI_BIT] = mie_q[IdxMei];
    end

    // Decoded straight from state so an asynchronous reset drops the request at once.
    assign irq_req_o    = (state_q == StReq);
    assign in_handler_o = (state_q == StHandler);
    assign irq_cause_o  = cause_q;
    assign gie_o        = gie_q;
    assign mpie_o       = mpie_q;

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Directed bench for irq_trap_ctrl. Stimulus pushes the expected trap request
// (cause plus edge index, -1 when timing is not pinned) into a scoreboard.
// A monitor pops the entry on each rising irq_req_o and checks that the cause
// held until the request fell.
module tb_irq_trap_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int Lat = 4;
`else
    localparam int Lat = 2;
`endif

    localparam logic [31:0] CMsi = 32'h8000_0003;
    localparam logic [31:0] CMti = 32'h8000_0007;
    localparam logic [31:0] CMei = 32'h8000_000B;

    typedef struct {
        logic [31:0] cause;
        int          cyc;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        timer_irq_i, soft_irq_i, ext_irq_i;
    logic        mie_we_i;
    logic [31:0] mie_wdata_i;
    logic        gie_we_i, gie_wdata_i;
    logic        irq_ack_i, mret_i;
    logic        irq_req_o;
    logic [31:0] irq_cause_o, mip_o, mie_o;
    logic        gie_o, mpie_o, in_handler_o;

    int   vecs = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t sb[$];

    irq_trap_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .timer_irq_i  (timer_irq_i),
        .soft_irq_i   (soft_irq_i),
        .ext_irq_i    (ext_irq_i),
        .mie_we_i     (mie_we_i),
        .mie_wdata_i  (mie_wdata_i),
        .gie_we_i     (gie_we_i),
        .gie_wdata_i  (gie_wdata_i),
        .irq_ack_i    (irq_ack_i),
        .mret_i       (mret_i),
        .irq_req_o    (irq_req_o),
        .irq_cause_o  (irq_cause_o),
        .mip_o        (mip_o),
        .mie_o        (mie_o),
        .gie_o        (gie_o),
        .mpie_o       (mpie_o),
        .in_handler_o (in_handler_o)
    );

    initial forever #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            if (irq_req_o) break;
            tick();
        end
        check("req_raised", {31'b0, irq_req_o}, 32'd1);
    endtask

    task automatic push(input logic [31:0] cause, input int at);
        exp_t e;
        e.cause = cause;
        e.cyc   = at;
        sb.push_back(e);
    endtask

    task automatic do_ack();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
    endtask

    task automatic do_mret();
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
    endtask

    // Monitor: scoreboard pop on request rise, cause-stability check on fall.
    initial begin
        exp_t        e;
        logic        req_seen;
        logic [31:0] cur_cause;
        req_seen  = 1'b0;
        cur_cause = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                req_seen = 1'b0;
            end else if (irq_req_o && !req_seen) begin
                req_seen = 1'b1;
                if (sb.size() == 0) begin
                    vecs++;
                    miscompares++;
                    $display("FAIL unexpected_req: got cause %h expected no request", irq_cause_o);
                    cur_cause = irq_cause_o;
                end else begin
                    e = sb.pop_front();
                    cur_cause = e.cause;
                    check("req_cause", irq_cause_o, e.cause);
                    if (e.cyc >= 0) check("req_latency", cyc, e.cyc);
                end
            end else if (!irq_req_o && req_seen) begin
                req_seen = 1'b0;
                check("cause_held", irq_cause_o, cur_cause);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni      = 1'b1;
        timer_irq_i = 1'b0;
        soft_irq_i  = 1'b0;
        ext_irq_i   = 1'b0;
        mie_we_i    = 1'b0;
        mie_wdata_i = '0;
        gie_we_i    = 1'b0;
        gie_wdata_i = 1'b0;
        irq_ack_i   = 1'b0;
        mret_i      = 1'b0;

        // 1: asynchronous reset between edges, then idle inputs.
        #7 rst_ni = 1'b0;
        #1;
        check("rst_req", {31'b0, irq_req_o}, 32'd0);
        check("rst_cause", irq_cause_o, 32'd0);
        check("rst_mip", mip_o, 32'd0);
        check("rst_mie", mie_o, 32'd0);
        check("rst_gie_mpie_hnd", {29'b0, gie_o, mpie_o, in_handler_o}, 32'd0);
        ticks(2);
        rst_ni = 1'b1;
        ticks(10);
        check("idle_no_req", {31'b0, irq_req_o}, 32'd0);

        // 2: timer interrupt, ack, mret.
        mie_we_i = 1'b1; mie_wdata_i = 32'h80; gie_we_i = 1'b1; gie_wdata_i = 1'b1;
        tick();
        mie_we_i = 1'b0; gie_we_i = 1'b0;
        check("mie_write", mie_o, 32'h80);
        check("gie_write", {31'b0, gie_o}, 32'd1);
        timer_irq_i = 1'b1;
        push(CMti, cyc + Lat);
        ticks(Lat);
        check("mip_timer", mip_o, 32'h80);
        wait_req();
        do_ack();
        check("ack_req_low", {31'b0, irq_req_o}, 32'd0);
        check("ack_gie_mpie_hnd", {29'b0, gie_o, mpie_o, in_handler_o}, 32'b011);
        timer_irq_i = 1'b0;
        ticks(Lat + 1);
        do_mret();
        check("mret_gie_mpie_hnd", {29'b0, gie_o, mpie_o, in_handler_o}, 32'b110);
        ticks(3);
        // mret and ack in IDLE are ignored.
        gie_we_i = 1'b1; gie_wdata_i = 1'b0;
        tick();
        gie_we_i = 1'b0;
        mret_i = 1'b1; irq_ack_i = 1'b1;
        tick();
        mret_i = 1'b0; irq_ack_i = 1'b0;
        check("idle_mret_ignored", {29'b0, gie_o, mpie_o, in_handler_o}, 32'b010);

        // 3: priority MEI > MSI > MTI.
        mie_we_i = 1'b1; mie_wdata_i = 32'hFFFF_FFFF; gie_we_i = 1'b1; gie_wdata_i = 1'b1;
        tick();
        mie_we_i = 1'b0; gie_we_i = 1'b0;
        check("mie_mask", mie_o, 32'h888);
        timer_irq_i = 1'b1; soft_irq_i = 1'b1; ext_irq_i = 1'b1;
        push(CMei, cyc + Lat);
        wait_req();
        ext_irq_i = 1'b0;
        do_ack();
        check("cause_kept_after_ack", irq_cause_o, CMei);
        push(CMsi, -1);
        ticks(Lat + 1);
        do_mret();
        wait_req();
        soft_irq_i = 1'b0;
        do_ack();
        push(CMti, -1);
        ticks(Lat + 1);
        do_mret();
        wait_req();

        // 4: request held stable while sources change.
        timer_irq_i = 1'b0; ext_irq_i = 1'b1;
        ticks(Lat + 3);
        check("held_req", {31'b0, irq_req_o}, 32'd1);
        check("held_cause", irq_cause_o, CMti);
        do_ack();
        ext_irq_i = 1'b0;
        ticks(Lat + 1);
        do_mret();
        check("mret_restore", {29'b0, gie_o, mpie_o, in_handler_o}, 32'b110);

        // 5: gie cleared while in REQ cancels; with ack in the same cycle, ack wins.
        timer_irq_i = 1'b1;
        push(CMti, cyc + Lat);
        wait_req();
        gie_we_i = 1'b1; gie_wdata_i = 1'b0;
        tick();
        gie_we_i = 1'b0;
        check("cancel_req_low", {31'b0, irq_req_o}, 32'd0);
        check("cancel_gie_hnd", {30'b0, gie_o, in_handler_o}, 32'd0);
        ticks(3);
        gie_we_i = 1'b1; gie_wdata_i = 1'b1;
        push(CMti, cyc + 2);
        tick();
        gie_we_i = 1'b0;
        wait_req();
        gie_we_i = 1'b1; gie_wdata_i = 1'b0; irq_ack_i = 1'b1;
        tick();
        gie_we_i = 1'b0; irq_ack_i = 1'b0;
        check("ack_wins_gie_mpie_hnd", {29'b0, gie_o, mpie_o, in_handler_o}, 32'b011);
        check("ack_wins_req_low", {31'b0, irq_req_o}, 32'd0);
        timer_irq_i = 1'b0;
        ticks(Lat + 1);
        do_mret();

        // 6: asynchronous reset during HANDLER.
        timer_irq_i = 1'b1;
        push(CMti, cyc + Lat);
        wait_req();
        do_ack();
        check("hnd_before_rst", {31'b0, in_handler_o}, 32'd1);
        #3 rst_ni = 1'b0;
        #1;
        check("rst_hnd_gie_mpie", {29'b0, gie_o, mpie_o, in_handler_o}, 32'd0);
        check("rst_cause_clear", irq_cause_o, 32'd0);
        timer_irq_i = 1'b0;
        ticks(2);
        rst_ni = 1'b1;
        ticks(Lat + 3);
        check("post_rst_no_req", {31'b0, irq_req_o}, 32'd0);

        check("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
